wptr_full_ctrl: RTL and testbench
=================================

Name: wptr_full_ctrl

Overview:
Write-domain pointer and status controller for the dual-clock asynchronous FIFO. It is the parametrised successor of the basic write-full block. It adds:
- an internal multi-stage synchroniser for the read-domain Gray pointer
- a write-side fill level
- a programmable almost-full flag
- a sticky overflow error
- RAM write-enable and address generation

It sits between the write client, the dual-port RAM, and the read-side pointer controller.

Parameters:
ADDR_W, 4, RAM address width; depth = 2**ADDR_W; legal range 2..12
SYNC_STAGES, 2, flops in the read-pointer synchroniser; legal range 2..4

Ports:
wclk  input  1  write-domain clock
wreset_n  input  1  reset, asynchronous, active-low
winc  input  1  write request from client
rptr_gray  input  ADDR_W+1  read pointer, Gray-coded, from the read clock domain (asynchronous)
afull_thresh  input  ADDR_W+1  almost-full threshold in entries, quasi-static
clr_ovf  input  1  single-cycle clear for wovf
wen  output  1  RAM write enable
waddr  output  ADDR_W  RAM write address
wptr_gray  output  ADDR_W+1  registered Gray write pointer, sent to the read domain
wfull  output  1  FIFO full
wafull  output  1  fill level >= afull_thresh
wlevel  output  ADDR_W+1  write-side fill level, 0..2**ADDR_W
wovf  output  1  sticky overflow: a write was attempted while full

Behaviour:
- Reset (async assert, sync release by system): wbin=0, wptr_gray=0, all synchroniser flops=0, wfull=0, wafull=0 (when afull_thresh=0, wafull becomes 1 on the first clock after reset), wlevel=0, wovf=0.
- Synchroniser: rptr_gray passes through SYNC_STAGES flops on wclk. Only the last stage, rq_gray, is used. rq_bin = gray2bin(rq_gray).
- Accept: wen = winc & ~wfull (combinational). waddr = wbin[ADDR_W-1:0].
- Binary pointer: wbin_next = wbin + wen, modulo 2**(ADDR_W+1). Wraps from 2**(ADDR_W+1)-1 to 0.
- Gray pointer: wgray_next = wbin_next ^ (wbin_next>>1), registered into wptr_gray.
  - wptr_gray comes straight from a flop; no combinational logic feeds the crossing.
  - Successive values differ in exactly 1 bit.
- Full: wfull <= (wgray_next == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]}). Registered, so it asserts on the clock edge that accepts the last free entry.
- Level: wlevel <= (wbin_next - rq_bin) mod 2**(ADDR_W+1).
  - Pessimistic: over-reports fill by up to SYNC_STAGES+1 read-clock updates.
  - Never under-reports.
- Almost-full: wafull <= (level_next >= afull_thresh).
  - afull_thresh = 0: wafull is always 1.
  - afull_thresh > 2**ADDR_W: wafull is never 1.
- Overflow: when winc & wfull, the write is dropped (no pointer change, wen=0) and wovf <= 1.
  - wovf holds until clr_ovf.
  - If set and clear happen in the same cycle, set wins.
- Full release latency: a read-pointer advance clears wfull SYNC_STAGES+1 wclk edges after rptr_gray changes.
- Reset mid-operation returns every output to its reset value immediately. Whatever is in the RAM is logically discarded.

Decomposition:
- Package fifo_pkg:
  - functions bin2gray and gray2bin, parametrised by width
  - default ADDR_W and SYNC_STAGES constants
- Sub-module cdc_sync_bus (WIDTH, STAGES): reset-able flop chain. Used for rptr_gray here and reused on the read side.
- All other logic stays in wptr_full_ctrl.

Test Plan:
1. Reset, ADDR_W=4, SYNC_STAGES=2 -> all outputs 0, waddr=0.
2. rptr_gray held 0, winc=1 for 16 cycles:
   - wen high 16 cycles, waddr 0..15
   - wfull=1 after the 16th edge, wptr_gray=5'b11000, wlevel=16
3. From the full state, winc=1 one more cycle:
   - wen=0, wptr_gray unchanged, wovf=1
   - clr_ovf pulse -> wovf=0
   - clr_ovf coincident with a new overflow write -> wovf stays 1
4. afull_thresh=12, rptr 0, 12 writes -> wafull=1 on the edge where wlevel=12; wafull=0 while wlevel=11.
5. Full, then drive rptr_gray=5'b00110 (binary 4) -> wfull=0 and wlevel=12 exactly 3 wclk edges later; the next write is accepted at waddr=0.
6. Continuous writes with rptr_gray trailing by 8 entries for 40 writes:
   - pointer wraps binary 31->0 (Gray 10000->00000)
   - wfull never asserts, wlevel stays 8..11, wovf=0

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default geometry and Gray/binary conversion.
package fifo_pkg;

    localparam int DEF_ADDR_W      = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Widest pointer any FIFO instance may use (ADDR_W up to 12, plus wrap bit).
    localparam int PTR_MAX_W = 13;

    // Callers zero-extend into PTR_MAX_W and cast the result back to their pointer width.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Reset-able multi-flop synchroniser for a Gray-coded bus entering a new clock domain.
module cdc_sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/status controller for the async FIFO: pointers, full, level,
// almost-full, sticky overflow and RAM write strobe/address.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              wclk,
    input  logic              wreset_n,
    input  logic              winc,
    input  logic [ADDR_W:0]   rptr_gray,
    input  logic [ADDR_W:0]   afull_thresh,
    input  logic              clr_ovf,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              wfull,
    output logic              wafull,
    output logic [ADDR_W:0]   wlevel,
    output logic              wovf
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wgray;
    logic          r_wfull;
    logic          r_wafull;
    logic [PW-1:0] r_wlevel;
    logic          r_wovf;

    logic [PW-1:0] w_rq_gray;
    logic [PW-1:0] w_rq_bin;
    logic          w_wen;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_full_gray;
    logic [PW-1:0] w_level_next;

    cdc_sync_bus #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .i_clk     (wclk),
        .i_reset_n (wreset_n),
        .i_d       (rptr_gray),
        .o_q       (w_rq_gray)
    );

    assign w_rq_bin     = PW'(gray2bin(PTR_MAX_W'(w_rq_gray)));
    assign w_wen        = winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + PW'(w_wen);
    assign w_wgray_next = PW'(bin2gray(PTR_MAX_W'(w_wbin_next)));
    assign w_level_next = w_wbin_next - w_rq_bin;

    // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
    assign w_full_gray  = {~w_rq_gray[PW-1:PW-2], w_rq_gray[PW-3:0]};

    always_ff @(posedge wclk or negedge wreset_n) begin
        if (!wreset_n) begin
            r_wbin   <= '0;
            r_wgray  <= '0;
            r_wfull  <= 1'b0;
            r_wafull <= 1'b0;
            r_wlevel <= '0;
            r_wovf   <= 1'b0;
        end else begin
            r_wbin   <= w_wbin_next;
            r_wgray  <= w_wgray_next;
            r_wfull  <= (w_wgray_next == w_full_gray);
            r_wafull <= (w_level_next >= afull_thresh);
            r_wlevel <= w_level_next;
            if (winc && r_wfull) begin
                r_wovf <= 1'b1;
            end else if (clr_ovf) begin
                r_wovf <= 1'b0;
            end
        end
    end

    assign wen       = w_wen;
    assign waddr     = r_wbin[ADDR_W-1:0];
    assign wptr_gray = r_wgray;
    assign wfull     = r_wfull;
    assign wafull    = r_wafull;
    assign wlevel    = r_wlevel;
    assign wovf      = r_wovf;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Randomised scoreboard bench for wptr_full_ctrl against a counter-based FIFO occupancy model.
module tb_wptr_full_ctrl;

    localparam int ADDR_W      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int PW          = ADDR_W + 1;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam int PMOD        = 1 << PW;

    logic              wclk = 1'b0;
    logic              wreset_n = 1'b0;
    logic              winc = 1'b0;
    logic              clr_ovf = 1'b0;
    logic [PW-1:0]     rptr_gray = '0;
    logic [PW-1:0]     afull_thresh = '0;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [PW-1:0]     wptr_gray;
    logic              wfull;
    logic              wafull;
    logic [PW-1:0]     wlevel;
    logic              wovf;

    typedef struct {
        bit wen;
        int waddr;
        int gray;
        bit full;
        bit afull;
        int level;
        bit ovf;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    int   cycle  = 0;

    int   mWcnt;
    int   mRcnt;
    bit   mFull;
    bit   mOvf;
    int   hist[$];

    always #5 wclk = ~wclk;

    wptr_full_ctrl #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .wclk         (wclk),
        .wreset_n     (wreset_n),
        .winc         (winc),
        .rptr_gray    (rptr_gray),
        .afull_thresh (afull_thresh),
        .clr_ovf      (clr_ovf),
        .wen          (wen),
        .waddr        (waddr),
        .wptr_gray    (wptr_gray),
        .wfull        (wfull),
        .wafull       (wafull),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    function automatic int toGray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input int got, input int expv);
        checks++;
        if (got == expv) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", name, cycle, got, expv);
        end
    endtask

    // The read pointer seen by the write side lags the driven value by SYNC_STAGES edges.
    task automatic resetModel();
        mWcnt = 0;
        mRcnt = 0;
        mFull = 0;
        mOvf  = 0;
        hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) begin
            hist.push_back(0);
        end
    endtask

    task automatic applyStimulus(input bit inc, input int rcnt, input int thresh, input bit clr);
        exp_t e;
        int   rq;
        int   lvl;
        @(negedge wclk);
        #1;
        winc         = inc;
        rptr_gray    = PW'(toGray(rcnt));
        afull_thresh = PW'(thresh);
        clr_ovf      = clr;
        mRcnt        = rcnt;
        hist.push_back(rcnt);
        rq = hist.pop_front();
        e.wen   = inc && !mFull;
        e.waddr = mWcnt % DEPTH;
        e.ovf   = (inc && mFull) ? 1'b1 : (clr ? 1'b0 : mOvf);
        if (e.wen) begin
            mWcnt = (mWcnt + 1) % PMOD;
        end
        lvl     = (mWcnt - rq + PMOD) % PMOD;
        e.level = lvl;
        e.full  = (lvl == DEPTH);
        e.afull = (lvl >= thresh);
        e.gray  = toGray(mWcnt);
        mFull   = e.full;
        mOvf    = e.ovf;
        expQ.push_back(e);
    endtask

    task automatic randomCycle(input int wrPct, input int rdPct, input int thresh);
        int  avail;
        int  rcnt;
        bit  inc;
        bit  clr;
        avail = (mWcnt - mRcnt + PMOD) % PMOD;
        rcnt  = mRcnt;
        if (avail > 0 && int'($urandom_range(99)) < rdPct) begin
            rcnt = (mRcnt + 1) % PMOD;
        end
        inc = (int'($urandom_range(99)) < wrPct);
        clr = ($urandom_range(9) == 0);
        applyStimulus(inc, rcnt, thresh, clr);
    endtask

    task automatic drainQueue();
        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(posedge wclk);
            #2;
        end
        checkOutput("scoreboard_drain", expQ.size(), 0);
    endtask

    // Monitor: wen/waddr are combinational and sampled before the edge, the rest just after it.
    initial begin
        exp_t e;
        bit   sWen;
        int   sAddr;
        forever begin
            @(negedge wclk);
            #2;
            sWen  = wen;
            sAddr = int'(waddr);
            @(posedge wclk);
            #1;
            cycle++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("wen",       int'(sWen),      int'(e.wen));
                if (e.wen) begin
                    checkOutput("waddr", sAddr,           e.waddr);
                end
                checkOutput("wptr_gray", int'(wptr_gray), e.gray);
                checkOutput("wfull",     int'(wfull),     int'(e.full));
                checkOutput("wafull",    int'(wafull),    int'(e.afull));
                checkOutput("wlevel",    int'(wlevel),    e.level);
                checkOutput("wovf",      int'(wovf),      int'(e.ovf));
            end
        end
    end

    initial begin
        int threshTab[6] = '{0, 5, 16, 17, 31, 9};
        int wrTab[6]     = '{90, 60, 95, 50, 80, 70};
        int rdTab[6]     = '{30, 60, 10, 55, 40, 50};

        $display("[TB] start");
        resetModel();
        repeat (3) @(posedge wclk);
        #1;
        checkOutput("rst_wen",       int'(wen),       0);
        checkOutput("rst_waddr",     int'(waddr),     0);
        checkOutput("rst_wptr_gray", int'(wptr_gray), 0);
        checkOutput("rst_wfull",     int'(wfull),     0);
        checkOutput("rst_wafull",    int'(wafull),    0);
        checkOutput("rst_wlevel",    int'(wlevel),    0);
        checkOutput("rst_wovf",      int'(wovf),      0);
        @(negedge wclk);
        wreset_n = 1'b1;

        // Fill to full with the reader parked, then overflow and clear interplay.
        repeat (DEPTH) applyStimulus(1, 0, 12, 0);
        applyStimulus(1, 0, 12, 0);
        applyStimulus(0, 0, 12, 1);
        applyStimulus(1, 0, 12, 1);
        applyStimulus(0, 0, 12, 1);

        // Reader frees four entries; full releases after the synchroniser latency.
        repeat (4) applyStimulus(0, 4, 12, 0);
        applyStimulus(1, 4, 12, 0);

        for (int p = 0; p < 6; p++) begin
            repeat (150) randomCycle(wrTab[p], rdTab[p], threshTab[p]);
        end
        drainQueue();

        @(negedge wclk);
        #1;
        winc      = 1'b0;
        clr_ovf   = 1'b0;
        rptr_gray = '0;
        wreset_n  = 1'b0;
        #1;
        checkOutput("midrst_wen",       int'(wen),       0);
        checkOutput("midrst_wptr_gray", int'(wptr_gray), 0);
        checkOutput("midrst_wfull",     int'(wfull),     0);
        checkOutput("midrst_wlevel",    int'(wlevel),    0);
        checkOutput("midrst_wovf",      int'(wovf),      0);
        @(negedge wclk);
        wreset_n = 1'b1;
        resetModel();
        repeat (60) randomCycle(85, 30, 7);
        drainQueue();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
